// File: rtl/app_if_responder_if.sv
// MIG 7-series user application interface bundle (command, write data, read data).
// The initiator uses the master modport; the responder uses the slave modport.
interface app_if_responder_if #(
  parameter int DATA_W = 256,
  parameter int MASK_W = 32,
  parameter int ADDR_W = 29
);
  logic [ADDR_W-1:0] app_addr;
  logic [2:0]        app_cmd;
  logic              app_en;
  logic              app_rdy;
  logic [DATA_W-1:0] app_wdf_data;
  logic [MASK_W-1:0] app_wdf_mask;
  logic              app_wdf_wren;
  logic              app_wdf_end;
  logic              app_wdf_rdy;
  logic [DATA_W-1:0] app_rd_data;
  logic              app_rd_data_valid;
  logic              app_rd_data_end;
  logic              init_calib_complete;

  modport master (
    output app_addr, app_cmd, app_en, app_wdf_data, app_wdf_mask, app_wdf_wren, app_wdf_end,
    input  app_rdy, app_wdf_rdy, app_rd_data, app_rd_data_valid, app_rd_data_end,
           init_calib_complete
  );

  modport slave (
    input  app_addr, app_cmd, app_en, app_wdf_data, app_wdf_mask, app_wdf_wren, app_wdf_end,
    output app_rdy, app_wdf_rdy, app_rd_data, app_rd_data_valid, app_rd_data_end,
           init_calib_complete
  );
endinterface

// File: rtl/app_if_responder.sv
// On-chip stand-in for the MIG 7-series user interface: command/write-data FIFOs, a small array and a read pipeline.
// Define APP_RESP_BACKPRESSURE_EN to throttle app_rdy/app_wdf_rdy with a free-running LFSR.
module app_if_responder #(
  parameter int DATA_W       = 256,
  parameter int MASK_W       = 32,
  parameter int ADDR_W       = 29,
  parameter int DEPTH_LOG2   = 5,
  parameter int RD_LATENCY   = 4,
  parameter int CALIB_CYCLES = 16
) (
  input logic               ui_clk,
  input logic               sys_rst,
  app_if_responder_if.slave app
);
  localparam int         DEPTH    = 1 << DEPTH_LOG2;
  localparam logic [2:0] CMD_WR   = 3'b000;
  localparam logic [2:0] CMD_RD   = 3'b001;
  localparam logic [2:0] FIFO_N   = 3'd4;
  localparam logic [15:0] CAL_LAST = 16'(CALIB_CYCLES - 1);

  typedef enum logic {ST_CALIB, ST_RUN} state_t;

  state_t            r_state;
  state_t            w_state_nxt;
  logic [15:0]       r_cal_cnt;

  logic [2:0]        r_cmd_q  [0:3];
  logic [ADDR_W-1:0] r_addr_q [0:3];
  logic [1:0]        r_cmd_wp;
  logic [1:0]        r_cmd_rp;
  logic [2:0]        r_cmd_cnt;
  logic [2:0]        w_cmd_cnt_nxt;

  logic [DATA_W-1:0] r_wd_q [0:3];
  logic [MASK_W-1:0] r_wm_q [0:3];
  logic [1:0]        r_wdf_wp;
  logic [1:0]        r_wdf_rp;
  logic [2:0]        r_wdf_cnt;
  logic [2:0]        w_wdf_cnt_nxt;

  logic              r_app_rdy;
  logic              r_wdf_rdy;
  logic              w_cmd_push;
  logic              w_wdf_push;
  logic              w_cmd_pop;
  logic              w_wdf_pop;
  logic              w_rd_exec;
  logic              w_wr_exec;
  logic              w_cmd_bp;
  logic              w_wdf_bp;

  logic [2:0]            w_head_cmd;
  logic [ADDR_W-1:0]     w_head_addr;
  logic [DEPTH_LOG2-1:0] w_idx;

  logic [DATA_W-1:0]     r_mem [0:DEPTH-1];

  logic [RD_LATENCY-1:0] r_vld_p;
  logic [DATA_W-1:0]     r_dat_p [0:RD_LATENCY-1];
  logic                  r_rd_vld;
  logic [DATA_W-1:0]     r_rd_data;

  logic                  w_unused;

  function automatic logic [DATA_W-1:0] f_merge(input logic [DATA_W-1:0] old_word,
                                                input logic [DATA_W-1:0] wdat,
                                                input logic [MASK_W-1:0] wmask);
    logic [DATA_W-1:0] res;
    res = old_word;
    for (int b = 0; b < MASK_W; b++) begin
      if (!wmask[b]) res[b*8 +: 8] = wdat[b*8 +: 8];
    end
    return res;
  endfunction

  // Calibration: count edges from reset release, then run until the next reset.
  always_ff @(posedge ui_clk or negedge sys_rst) begin
    if (!sys_rst) begin
      r_state   <= ST_CALIB;
      r_cal_cnt <= 16'd0;
    end else begin
      r_state <= w_state_nxt;
      if (r_state == ST_CALIB) r_cal_cnt <= r_cal_cnt + 16'd1;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_CALIB: if (r_cal_cnt == CAL_LAST) w_state_nxt = ST_RUN;
      ST_RUN:   w_state_nxt = ST_RUN;
      default:  w_state_nxt = ST_CALIB;
    endcase
  end

`ifdef APP_RESP_BACKPRESSURE_EN
  logic [15:0] r_lfsr;
  logic [15:0] w_lfsr_nxt;

  always_comb begin
    w_lfsr_nxt = r_lfsr;
    if (r_state == ST_RUN) w_lfsr_nxt = {r_lfsr[0] ^ r_lfsr[2] ^ r_lfsr[3] ^ r_lfsr[5], r_lfsr[15:1]};
  end

  always_ff @(posedge ui_clk or negedge sys_rst) begin
    if (!sys_rst) r_lfsr <= 16'hACE1;
    else          r_lfsr <= w_lfsr_nxt;
  end

  // Ready is registered, so the throttle looks at the value the LFSR will hold next cycle.
  assign w_cmd_bp = (w_lfsr_nxt[1:0] == 2'b00);
  assign w_wdf_bp = (w_lfsr_nxt[3:2] == 2'b00);
`else
  assign w_cmd_bp = 1'b0;
  assign w_wdf_bp = 1'b0;
`endif

  assign w_cmd_push  = app.app_en & r_app_rdy;
  assign w_wdf_push  = app.app_wdf_wren & r_wdf_rdy;
  assign w_head_cmd  = r_cmd_q[r_cmd_rp];
  assign w_head_addr = r_addr_q[r_cmd_rp];
  assign w_idx       = w_head_addr[DEPTH_LOG2+2:3];

  // Execute stage: one head command per cycle; a write waits for its data beat.
  always_comb begin
    w_cmd_pop = 1'b0;
    w_wdf_pop = 1'b0;
    w_rd_exec = 1'b0;
    w_wr_exec = 1'b0;
    if (r_cmd_cnt != 3'd0) begin
      if (w_head_cmd == CMD_RD) begin
        w_cmd_pop = 1'b1;
        w_rd_exec = 1'b1;
      end else if (w_head_cmd == CMD_WR) begin
        if (r_wdf_cnt != 3'd0) begin
          w_cmd_pop = 1'b1;
          w_wdf_pop = 1'b1;
          w_wr_exec = 1'b1;
        end
      end else begin
        w_cmd_pop = 1'b1;
      end
    end
  end

  assign w_cmd_cnt_nxt = r_cmd_cnt + {2'b00, w_cmd_push} - {2'b00, w_cmd_pop};
  assign w_wdf_cnt_nxt = r_wdf_cnt + {2'b00, w_wdf_push} - {2'b00, w_wdf_pop};

  always_ff @(posedge ui_clk or negedge sys_rst) begin
    if (!sys_rst) begin
      r_cmd_wp  <= 2'd0;
      r_cmd_rp  <= 2'd0;
      r_cmd_cnt <= 3'd0;
      r_wdf_wp  <= 2'd0;
      r_wdf_rp  <= 2'd0;
      r_wdf_cnt <= 3'd0;
      r_app_rdy <= 1'b0;
      r_wdf_rdy <= 1'b0;
    end else begin
      if (w_cmd_push) r_cmd_wp <= r_cmd_wp + 2'd1;
      if (w_cmd_pop)  r_cmd_rp <= r_cmd_rp + 2'd1;
      if (w_wdf_push) r_wdf_wp <= r_wdf_wp + 2'd1;
      if (w_wdf_pop)  r_wdf_rp <= r_wdf_rp + 2'd1;
      r_cmd_cnt <= w_cmd_cnt_nxt;
      r_wdf_cnt <= w_wdf_cnt_nxt;
      r_app_rdy <= (w_state_nxt == ST_RUN) && (w_cmd_cnt_nxt != FIFO_N) && !w_cmd_bp;
      r_wdf_rdy <= (w_state_nxt == ST_RUN) && (w_wdf_cnt_nxt != FIFO_N) && !w_wdf_bp;
    end
  end

  always_ff @(posedge ui_clk) begin
    if (w_cmd_push) begin
      r_cmd_q[r_cmd_wp]  <= app.app_cmd;
      r_addr_q[r_cmd_wp] <= app.app_addr;
    end
    if (w_wdf_push) begin
      r_wd_q[r_wdf_wp] <= app.app_wdf_data;
      r_wm_q[r_wdf_wp] <= app.app_wdf_mask;
    end
    if (w_wr_exec) r_mem[w_idx] <= f_merge(r_mem[w_idx], r_wd_q[r_wdf_rp], r_wm_q[r_wdf_rp]);
  end

  // Read pipeline: stage p0 captures the array word at execute, output register follows the last stage.
  always_ff @(posedge ui_clk or negedge sys_rst) begin
    if (!sys_rst) begin
      r_vld_p   <= '0;
      r_rd_vld  <= 1'b0;
      r_rd_data <= '0;
    end else begin
      r_vld_p[0] <= w_rd_exec;
      for (int i = 1; i < RD_LATENCY; i++) r_vld_p[i] <= r_vld_p[i-1];
      r_rd_vld <= r_vld_p[RD_LATENCY-1];
      if (r_vld_p[RD_LATENCY-1]) r_rd_data <= r_dat_p[RD_LATENCY-1];
    end
  end

  always_ff @(posedge ui_clk) begin
    r_dat_p[0] <= r_mem[w_idx];
    for (int i = 1; i < RD_LATENCY; i++) r_dat_p[i] <= r_dat_p[i-1];
  end

  assign app.app_rdy             = r_app_rdy;
  assign app.app_wdf_rdy         = r_wdf_rdy;
  assign app.app_rd_data         = r_rd_data;
  assign app.app_rd_data_valid   = r_rd_vld;
  assign app.app_rd_data_end     = r_rd_vld;
  assign app.init_calib_complete = (r_state == ST_RUN);

  // Single-beat interface: wdf_end carries no information here.
  assign w_unused = app.app_wdf_end;
endmodule

// File: tb/tb_app_if_responder.sv
// Self-checking bench for app_if_responder: vector table, hand-written corner sequences and a read-data scoreboard.
module tb_app_if_responder;
  localparam int DATA_W       = 256;
  localparam int MASK_W       = 32;
  localparam int ADDR_W       = 29;
  localparam int DEPTH_LOG2   = 5;
  localparam int RD_LATENCY   = 4;
  localparam int CALIB_CYCLES = 16;
  localparam int DEPTH        = 1 << DEPTH_LOG2;
  localparam int TMO          = 300;

  logic ui_clk  = 1'b0;
  logic sys_rst = 1'b1;
  always #5 ui_clk = ~ui_clk;

  app_if_responder_if #(.DATA_W(DATA_W), .MASK_W(MASK_W), .ADDR_W(ADDR_W)) bus ();

  app_if_responder #(
    .DATA_W(DATA_W), .MASK_W(MASK_W), .ADDR_W(ADDR_W), .DEPTH_LOG2(DEPTH_LOG2),
    .RD_LATENCY(RD_LATENCY), .CALIB_CYCLES(CALIB_CYCLES)
  ) dut (
    .ui_clk(ui_clk),
    .sys_rst(sys_rst),
    .app(bus.slave)
  );

  typedef struct {
    logic              is_rd;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] data;
    logic [MASK_W-1:0] mask;
    logic [DATA_W-1:0] exp;
  } vec_t;

  localparam int NV = 12;
  vec_t vt [NV];

  int n_chk = 0;
  int n_fail = 0;
  int cyc = 0;
  logic [DATA_W-1:0] model [0:DEPTH-1];
  logic [DATA_W-1:0] sb_q [$];
  int beat_cyc [$];

  always @(posedge ui_clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [DATA_W-1:0] act, input logic [DATA_W-1:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Read-data monitor: every valid beat must match the oldest outstanding expectation.
  always @(negedge ui_clk) begin
    if (bus.app_rd_data_valid === 1'b1) begin
      beat_cyc.push_back(cyc);
      chk("rd_data_end", DATA_W'(bus.app_rd_data_end), DATA_W'(1));
      if (sb_q.size() == 0) begin
        n_chk++;
        n_fail++;
        $display("FAIL rd_unexpected: got beat %h expected no beat", bus.app_rd_data);
      end else begin
        chk("rd_data", bus.app_rd_data, sb_q.pop_front());
      end
    end
  end

  function automatic logic [DATA_W-1:0] rnd256();
    logic [DATA_W-1:0] r;
    for (int i = 0; i < DATA_W/32; i++) r[i*32 +: 32] = $urandom();
    return r;
  endfunction

  function automatic logic [DEPTH_LOG2-1:0] idx_of(input logic [ADDR_W-1:0] a);
    return a[DEPTH_LOG2+2:3];
  endfunction

  task automatic model_write(input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] d, input logic [MASK_W-1:0] m);
    for (int b = 0; b < MASK_W; b++) begin
      if (!m[b]) model[idx_of(a)][b*8 +: 8] = d[b*8 +: 8];
    end
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge ui_clk);
  endtask

  task automatic send_cmd(input logic [2:0] cmd, input logic [ADDR_W-1:0] a);
    int t = 0;
    bus.app_en   = 1'b1;
    bus.app_cmd  = cmd;
    bus.app_addr = a;
    while (bus.app_rdy !== 1'b1 && t < TMO) begin
      @(negedge ui_clk);
      t++;
    end
    if (t >= TMO) begin
      n_chk++;
      n_fail++;
      $display("FAIL cmd_accept: got app_rdy low for %0d cycles required acceptance", t);
    end
    @(negedge ui_clk);
    bus.app_en = 1'b0;
  endtask

  task automatic send_dat(input logic [DATA_W-1:0] d, input logic [MASK_W-1:0] m);
    int t = 0;
    bus.app_wdf_wren = 1'b1;
    bus.app_wdf_end  = 1'b1;
    bus.app_wdf_data = d;
    bus.app_wdf_mask = m;
    while (bus.app_wdf_rdy !== 1'b1 && t < TMO) begin
      @(negedge ui_clk);
      t++;
    end
    if (t >= TMO) begin
      n_chk++;
      n_fail++;
      $display("FAIL wdf_accept: got app_wdf_rdy low for %0d cycles required acceptance", t);
    end
    @(negedge ui_clk);
    bus.app_wdf_wren = 1'b0;
    bus.app_wdf_end  = 1'b0;
  endtask

  task automatic wr(input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] d, input logic [MASK_W-1:0] m);
    model_write(a, d, m);
    fork
      send_cmd(3'b000, a);
      send_dat(d, m);
    join
  endtask

  task automatic rd(input logic [ADDR_W-1:0] a);
    sb_q.push_back(model[idx_of(a)]);
    send_cmd(3'b001, a);
  endtask

  task automatic drain();
    int t = 0;
    while (sb_q.size() != 0 && t < 500) begin
      @(negedge ui_clk);
      t++;
    end
    chk("drain_outstanding", DATA_W'(sb_q.size()), DATA_W'(0));
    sb_q.delete();
  endtask

  task automatic chk_outputs_zero(input string tag);
    chk({tag, "_calib"}, DATA_W'(bus.init_calib_complete), DATA_W'(0));
    chk({tag, "_app_rdy"}, DATA_W'(bus.app_rdy), DATA_W'(0));
    chk({tag, "_wdf_rdy"}, DATA_W'(bus.app_wdf_rdy), DATA_W'(0));
    chk({tag, "_rd_valid"}, DATA_W'(bus.app_rd_data_valid), DATA_W'(0));
    chk({tag, "_rd_end"}, DATA_W'(bus.app_rd_data_end), DATA_W'(0));
    chk({tag, "_rd_data"}, bus.app_rd_data, DATA_W'(0));
  endtask

  task automatic calib_seq(input string tag);
    for (int k = 1; k <= CALIB_CYCLES + 1; k++) begin
      @(negedge ui_clk);
      chk({tag, "_calib"}, DATA_W'(bus.init_calib_complete), DATA_W'(k >= CALIB_CYCLES));
`ifndef APP_RESP_BACKPRESSURE_EN
      chk({tag, "_app_rdy"}, DATA_W'(bus.app_rdy), DATA_W'(k >= CALIB_CYCLES));
      chk({tag, "_wdf_rdy"}, DATA_W'(bus.app_wdf_rdy), DATA_W'(k >= CALIB_CYCLES));
`endif
    end
  endtask

  initial begin
    #20_000_000;
    $display("FAIL watchdog: got no end of test required completion");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [ADDR_W-1:0] fa [5];
    logic [DATA_W-1:0] fd [5];
    logic [DATA_W-1:0] d;
    logic [MASK_W-1:0] m;
    logic [ADDR_W-1:0] a;
    int skew;

    vt[0]  = '{1'b0, 29'h0000_0000, 256'h2,              32'h0000_0000, 256'h0};
    vt[1]  = '{1'b1, 29'h0000_0000, 256'h0,              32'h0000_0000, 256'h2};
    vt[2]  = '{1'b0, 29'h0000_0008, 256'h0,              32'h0000_0000, 256'h0};
    vt[3]  = '{1'b0, 29'h0000_0008, {DATA_W{1'b1}},      32'hFFFF_FFFE, 256'h0};
    vt[4]  = '{1'b1, 29'h0000_0008, 256'h0,              32'h0000_0000, 256'hFF};
    vt[5]  = '{1'b0, 29'h0000_0100, 256'hABCD,           32'h0000_0000, 256'h0};
    vt[6]  = '{1'b1, 29'h0000_0000, 256'h0,              32'h0000_0000, 256'hABCD};
    vt[7]  = '{1'b1, 29'h0000_0007, 256'h0,              32'h0000_0000, 256'hABCD};
    vt[8]  = '{1'b1, 29'h1FFF_FF07, 256'h0,              32'h0000_0000, 256'hABCD};
    vt[9]  = '{1'b0, 29'h0000_0010, 256'h55,             32'h0000_0000, 256'h0};
    vt[10] = '{1'b0, 29'h0000_0010, 256'h1234,           32'hFFFF_FFFD, 256'h0};
    vt[11] = '{1'b1, 29'h0000_0010, 256'h0,              32'h0000_0000, 256'h1255};

    bus.app_en       = 1'b0;
    bus.app_cmd      = 3'b000;
    bus.app_addr     = '0;
    bus.app_wdf_wren = 1'b0;
    bus.app_wdf_end  = 1'b0;
    bus.app_wdf_data = '0;
    bus.app_wdf_mask = '0;

    // Reset and calibration
    #1 sys_rst = 1'b0;
    idle(3);
    chk_outputs_zero("reset");
    sys_rst = 1'b1;
    calib_seq("cal");

    for (int i = 0; i < DEPTH; i++) wr(ADDR_W'(i * 8), rnd256(), '0);

    // Vector table
    for (int i = 0; i < NV; i++) begin
      if (vt[i].is_rd) begin
        sb_q.push_back(vt[i].exp);
        send_cmd(3'b001, vt[i].addr);
      end else begin
        wr(vt[i].addr, vt[i].data, vt[i].mask);
      end
    end
    drain();

    // Exact read latency from acceptance
    idle(3);
    wr(ADDR_W'(3 * 8), 256'h77, '0);
    idle(3);
    sb_q.push_back(256'h77);
    send_cmd(3'b001, ADDR_W'(3 * 8));
    for (int k = 1; k <= RD_LATENCY; k++) begin
      @(negedge ui_clk);
      chk("lat_early_valid", DATA_W'(bus.app_rd_data_valid), DATA_W'(0));
    end
    @(negedge ui_clk);
    chk("lat_valid", DATA_W'(bus.app_rd_data_valid), DATA_W'(1));
    drain();

    // Command FIFO fills while writes wait for data, then all commit in order
    for (int i = 0; i < 5; i++) begin
      fa[i] = ADDR_W'((20 + (i % 4)) * 8);
      fd[i] = rnd256();
      model_write(fa[i], fd[i], '0);
    end
    for (int i = 0; i < 4; i++) begin
`ifndef APP_RESP_BACKPRESSURE_EN
      chk("fill_rdy_before", DATA_W'(bus.app_rdy), DATA_W'(1));
`endif
      send_cmd(3'b000, fa[i]);
    end
`ifndef APP_RESP_BACKPRESSURE_EN
    chk("fill_rdy_full", DATA_W'(bus.app_rdy), DATA_W'(0));
    idle(2);
    chk("fill_rdy_held", DATA_W'(bus.app_rdy), DATA_W'(0));
`endif
    fork
      send_cmd(3'b000, fa[4]);
      begin
        for (int i = 0; i < 5; i++) send_dat(fd[i], '0);
      end
    join
    for (int i = 0; i < 4; i++) rd(fa[i]);
    drain();

    // Write data three cycles ahead of its command, and three cycles behind
    d = rnd256();
    a = ADDR_W'(26 * 8);
    model_write(a, d, 32'h0000_FFFF);
    send_dat(d, 32'h0000_FFFF);
    idle(2);
    send_cmd(3'b000, a);
    rd(a);
    d = rnd256();
    a = ADDR_W'(27 * 8);
    model_write(a, d, '0);
    fork
      send_cmd(3'b000, a);
      begin
        idle(3);
        send_dat(d, '0);
      end
    join
    rd(a);
    rd(ADDR_W'(26 * 8));
    drain();

    // Back-to-back reads
    idle(2);
    beat_cyc.delete();
    for (int i = 0; i < 30; i++) rd(ADDR_W'(((i * 7) % DEPTH) * 8));
    drain();
    chk("b2b_beats", DATA_W'(beat_cyc.size()), DATA_W'(30));
`ifndef APP_RESP_BACKPRESSURE_EN
    if (beat_cyc.size() == 30) chk("b2b_span", DATA_W'(beat_cyc[29] - beat_cyc[0]), DATA_W'(29));
`endif

    // Random traffic
    for (int n = 0; n < 200; n++) begin
      a = ADDR_W'($urandom());
      if ($urandom_range(0, 1) == 1) begin
        rd(a);
      end else begin
        d    = rnd256();
        m    = ($urandom_range(0, 2) == 0) ? MASK_W'($urandom()) : '0;
        skew = $urandom_range(0, 2);
        model_write(a, d, m);
        fork
          send_cmd(3'b000, a);
          begin
            idle(skew);
            send_dat(d, m);
          end
        join
      end
      if ($urandom_range(0, 7) == 0) idle(1);
    end
    drain();

    // Asynchronous reset with a read in flight
    rd(ADDR_W'(5 * 8));
    drain();
    send_cmd(3'b001, ADDR_W'(6 * 8));
    @(posedge ui_clk);
    #2 sys_rst = 1'b0;
    #1 chk_outputs_zero("async_reset");
    idle(2);
    sys_rst = 1'b1;
    calib_seq("recal");
    idle(RD_LATENCY + 4);
    rd(ADDR_W'(5 * 8));
    drain();

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/app_if_responder.md
# app_if_responder

Synthesizable responder for the MIG 7-series user application interface. It accepts commands and write data from a user-side initiator and returns read data, with the same signal semantics as the MIG core. Storage is a small on-chip array rather than DDR3, so a sequencer can be brought up and verified without the memory controller. It sits in the `ui_clk` domain in place of `mig_7series_0`, for simulation and for board bring-up.

## Interface
- `DATA_W`, 256: width of `app_wdf_data` and `app_rd_data`.
- `MASK_W`, 32: write byte-mask width; always `DATA_W/8`.
- `ADDR_W`, 29: width of `app_addr`.
- `DEPTH_LOG2`, 5: log2 of the number of stored words (default 32 words).
- `RD_LATENCY`, 4: pipeline stages between read execution and `app_rd_data_valid`; range 1..15.
- `CALIB_CYCLES`, 16: cycles after reset release before calibration completes; range 1..65535.
- `ui_clk`  in  1  sole clock.
- `sys_rst`  in  1  reset; asynchronous, active-low.
- `app_addr`  in  ADDR_W  command address.
- `app_cmd`  in  3  3'b000 = write, 3'b001 = read.
- `app_en`  in  1  command valid.
- `app_rdy`  out  1  command ready.
- `app_wdf_data`  in  DATA_W  write data.
- `app_wdf_mask`  in  MASK_W  byte mask; 1 = byte not written.
- `app_wdf_wren`  in  1  write data valid.
- `app_wdf_end`  in  1  last beat; accepted and ignored (single-beat interface).
- `app_wdf_rdy`  out  1  write data ready.
- `app_rd_data`  out  DATA_W  read data.
- `app_rd_data_valid`  out  1  read data valid.
- `app_rd_data_end`  out  1  equals `app_rd_data_valid`.
- `init_calib_complete`  out  1  calibration done.

## Operation
- **Reset (`sys_rst` = 0):**
  - All outputs are 0.
  - Both FIFOs are empty, the read pipeline is flushed and the calibration counter is cleared.
  - Array contents are not reset.
  - An in-flight read is dropped and produces no valid beat after reset.
- **Calibration:** a counter runs from reset release. `init_calib_complete` rises after `CALIB_CYCLES` edges and stays high until the next reset.
- **Command FIFO:**
  - 4 entries, each holding {cmd, addr}.
  - `app_rdy` = calib & !cmd_full.
  - A command is accepted on `app_en & app_rdy`.
- **Write-data FIFO:**
  - 4 entries, each holding {data, mask}.
  - `app_wdf_rdy` = calib & !wdf_full.
  - A beat is accepted on `app_wdf_wren & app_wdf_rdy`.
  - Write data may arrive before, with, or after its write command.
- **Fullness:** "full" is evaluated before any same-cycle pop. A full FIFO never accepts, even when it pops in the same cycle.
- **Execute engine:** at most one head command per cycle.
  - Read: the array word is read and enters the latency pipeline; the command is popped.
  - Write: stalls while the write-data FIFO is empty. Otherwise the byte-masked write commits to the array and both heads are popped.
  - Any other cmd value: popped with no effect.
- **Word index:** `app_addr[DEPTH_LOG2+2:3]`.
  - The low 3 bits (BL8 column offset) are ignored.
  - Higher bits are ignored, so the address aliases and wraps modulo the depth.
- **Ordering:**
  - Commands execute strictly in order.
  - A read that follows a write to the same index returns the new data.
  - Read data returns in command order.

## Timing
- **Read latency:** a read accepted at edge N, with the command FIFO empty, executes at edge N+1. `app_rd_data_valid` is then high for exactly one cycle, after edge N+1+RD_LATENCY.
- **Back-to-back reads** produce back-to-back valid beats.
- **Full throughput:** one command plus one write beat per cycle.
- **Write stall:** if a write command's data arrives K cycles after the command, execution is delayed by K cycles. Later reads are delayed behind it.
- **Outputs:** `app_rdy` and `app_wdf_rdy` are registered. `app_rd_data` holds its last value while valid is low.

## Configuration
- **`APP_RESP_BACKPRESSURE_EN` defined:**
  - A 16-bit LFSR (seed 16'hACE1, polynomial x^16+x^14+x^13+x^11+1) advances every cycle after calibration.
  - `app_rdy` is additionally forced low when lfsr[1:0] == 2'b00.
  - `app_wdf_rdy` is additionally forced low when lfsr[3:2] == 2'b00.
  - This exercises initiator stall handling.
- **Undefined:** ready depends only on calibration and FIFO fullness.

## Test plan
- **Reset and calibration:** release reset with CALIB_CYCLES=16 -> `init_calib_complete`, `app_rdy` and `app_wdf_rdy` are 0 for 16 edges, then 1. Assert reset mid-run -> all outputs 0 asynchronously.
- **Write then read:** write data 256'h2 to addr 0, then read addr 0 -> one valid beat carrying 256'h2, exactly 1+RD_LATENCY cycles after the read is accepted.
- **Masked write:** write all-ones to addr 8 with mask 32'hFFFF_FFFE, after a prior write of 0 -> readback is 256'h00…0FF.
- **Data/command skew and fullness:**
  - Issue 5 write commands with no write data -> `app_rdy` drops after the 4th command is accepted.
  - Then supply the data -> all 5 writes commit in order.
  - Write data arriving 3 cycles before its command is also correct.
- **Ordering and aliasing:**
  - Write addr 0x100 (index 0 with DEPTH_LOG2=5), then read addr 0 -> returns the aliased data.
  - 30 back-to-back reads -> 30 contiguous valid beats, in issue order.
- **Backpressure (macro defined):** random traffic of 200 commands -> every read returns the last value written to its index, with no lost or duplicated beats.
